// File: rtl/en_delay_line.sv
// Enable-gated delay line with per-stage valid bits, run-time output tap,
// synchronous flush and a registered occupancy count.
module en_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned SELW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic [SELW-1:0]  dly_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  occupancy
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [SELW-1:0]  occ_d;
  int unsigned      tap;

  // Next stage contents: flush clears, enable shifts, otherwise hold
  always_comb begin
    stage_d = stage_q;
    vld_d   = vld_q;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] = '0;
      end
      vld_d = '0;
    end else if (en) begin
      stage_d[0] = in_data;
      vld_d[0]   = in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
        vld_d[i]   = vld_q[i-1];
      end
    end
  end

  // Occupancy follows the next-state valid bits so it lands on the same edge
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + SELW'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      vld_q     <= '0;
      occupancy <= '0;
    end else begin
      stage_q   <= stage_d;
      vld_q     <= vld_d;
      occupancy <= occ_d;
    end
  end

  // Tap select: zero and out-of-range values clamp to the last stage
  always_comb begin
    tap = DEPTH - 32'd1;
    if (dly_sel != '0 && 32'(dly_sel) <= DEPTH) begin
      tap = 32'(dly_sel) - 32'd1;
    end
  end

  // Invalid words are masked to zero so stale data never leaks downstream
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (32'(i) == tap) begin
        out_valid = vld_q[i];
        out_data  = vld_q[i] ? stage_q[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_en_delay_line.sv
// Bench for en_delay_line: two instances (depth 2 and depth 4) checked with
// directed scenarios and a randomized run against a queue-based model.
module tb_en_delay_line;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
  } word_t;

  logic       clk;
  logic       rst;
  logic       en2, iv2, fl2;
  logic [3:0] id2;
  logic [1:0] sel2;
  logic       ov2;
  logic [3:0] od2;
  logic [1:0] occ2;
  logic       en4, iv4, fl4;
  logic [3:0] id4;
  logic [2:0] sel4;
  logic       ov4;
  logic [3:0] od4;
  logic [2:0] occ4;

  int checks = 0;
  int errors = 0;

  word_t m2[$];
  word_t m4[$];

  en_delay_line #(.WIDTH(4), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en2), .in_valid(iv2), .in_data(id2),
    .flush(fl2), .dly_sel(sel2), .out_valid(ov2), .out_data(od2), .occupancy(occ2)
  );

  en_delay_line #(.WIDTH(4), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en4), .in_valid(iv4), .in_data(id4),
    .flush(fl4), .dly_sel(sel4), .out_valid(ov4), .out_data(od4), .occupancy(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: newest word at the front of the queue, oldest falls off the back
  task automatic model_update();
    if (rst) begin
      foreach (m2[i]) m2[i] = '0;
      foreach (m4[i]) m4[i] = '0;
    end else begin
      if (fl2) begin
        foreach (m2[i]) m2[i] = '0;
      end else if (en2) begin
        m2.push_front({iv2, id2});
        void'(m2.pop_back());
      end
      if (fl4) begin
        foreach (m4[i]) m4[i] = '0;
      end else if (en4) begin
        m4.push_front({iv4, id4});
        void'(m4.pop_back());
      end
    end
  endtask

  function automatic int tap_k(int sel, int depth);
    return (sel >= 1 && sel <= depth) ? sel : depth;
  endfunction

  function automatic word_t exp2();
    word_t w;
    w = m2[tap_k(int'(sel2), 2) - 1];
    return w.v ? w : '0;
  endfunction

  function automatic word_t exp4();
    word_t w;
    w = m4[tap_k(int'(sel4), 4) - 1];
    return w.v ? w : '0;
  endfunction

  function automatic int count_valid2();
    int c = 0;
    foreach (m2[i]) if (m2[i].v) c++;
    return c;
  endfunction

  function automatic int count_valid4();
    int c = 0;
    foreach (m4[i]) if (m4[i].v) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en2 = 0; iv2 = 0; id2 = '0; fl2 = 0; sel2 = 2'd2;
    en4 = 0; iv4 = 0; id4 = '0; fl4 = 0; sel4 = 3'd4;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ov2, od2, occ2} !== 7'd0) begin
      errors++;
      $display("FAIL reset_d2 got v=%b d=%h occ=%0d want v=0 d=0 occ=0", ov2, od2, occ2);
    end
    checks++;
    if ({ov4, od4, occ4} !== 8'd0) begin
      errors++;
      $display("FAIL reset_d4 got v=%b d=%h occ=%0d want v=0 d=0 occ=0", ov4, od4, occ4);
    end
  endtask

  task automatic test_pipeline();
    logic [3:0] din [4]  = '{4'h5, 4'h9, 4'hC, 4'h3};
    logic       wv  [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] wd  [4]  = '{4'h0, 4'h5, 4'h9, 4'hC};
    logic [1:0] wo  [4]  = '{2'd1, 2'd2, 2'd2, 2'd2};
    do_reset();
    sel2 = 2'd2; en2 = 1; iv2 = 1;
    for (int e = 0; e < 4; e++) begin
      id2 = din[e];
      tick();
      checks++;
      if (ov2 !== wv[e] || od2 !== wd[e] || occ2 !== wo[e]) begin
        errors++;
        $display("FAIL pipeline_edge%0d got v=%b d=%h occ=%0d want v=%b d=%h occ=%0d",
                 e + 1, ov2, od2, occ2, wv[e], wd[e], wo[e]);
      end
    end
    en2 = 0; iv2 = 0;
  endtask

  task automatic test_hold();
    do_reset();
    sel2 = 2'd2; en2 = 1; iv2 = 1; id2 = 4'hA;
    tick();
    en2 = 0; iv2 = 1; id2 = 4'h6;
    for (int e = 2; e <= 3; e++) begin
      tick();
      checks++;
      if (ov2 !== 1'b0 || od2 !== 4'h0 || occ2 !== 2'd1) begin
        errors++;
        $display("FAIL hold_edge%0d got v=%b d=%h occ=%0d want v=0 d=0 occ=1", e, ov2, od2, occ2);
      end
    end
    en2 = 1; iv2 = 0; id2 = 4'h7;
    tick();
    en2 = 0;
    for (int e = 4; e <= 5; e++) begin
      checks++;
      if (ov2 !== 1'b1 || od2 !== 4'hA || occ2 !== 2'd1) begin
        errors++;
        $display("FAIL hold_visible%0d got v=%b d=%h occ=%0d want v=1 d=a occ=1", e, ov2, od2, occ2);
      end
      tick();
    end
  endtask

  task automatic test_tap_sweep();
    logic [2:0] sels [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
    logic [3:0] want [6] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h1, 4'h1};
    do_reset();
    en4 = 1; iv4 = 1;
    for (int i = 1; i <= 4; i++) begin
      id4 = 4'(i);
      tick();
    end
    en4 = 0; iv4 = 0;
    checks++;
    if (occ4 !== 3'd4) begin
      errors++;
      $display("FAIL sweep_occ got %0d want 4", occ4);
    end
    for (int i = 0; i < 6; i++) begin
      sel4 = sels[i];
      #1;
      checks++;
      if (ov4 !== 1'b1 || od4 !== want[i]) begin
        errors++;
        $display("FAIL sweep_sel%0d got v=%b d=%h want v=1 d=%h", sels[i], ov4, od4, want[i]);
      end
    end
    sel4 = 3'd4;
  endtask

  task automatic test_flush();
    do_reset();
    sel2 = 2'd2; en2 = 1; iv2 = 1; id2 = 4'h1;
    tick();
    id2 = 4'h2;
    tick();
    fl2 = 1; id2 = 4'hF;
    tick();
    fl2 = 0; en2 = 0;
    checks++;
    if ({ov2, od2, occ2} !== 7'd0) begin
      errors++;
      $display("FAIL flush_tap2 got v=%b d=%h occ=%0d want v=0 d=0 occ=0", ov2, od2, occ2);
    end
    sel2 = 2'd1;
    #1;
    checks++;
    if (ov2 !== 1'b0 || od2 !== 4'h0) begin
      errors++;
      $display("FAIL flush_f_absent got v=%b d=%h want v=0 d=0", ov2, od2);
    end
    sel2 = 2'd2;
  endtask

  task automatic test_gap_and_reset();
    logic       vin  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] din  [4] = '{4'h7, 4'h8, 4'h9, 4'h5};
    logic       wv   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] wd   [4] = '{4'h0, 4'h7, 4'h0, 4'h9};
    do_reset();
    sel2 = 2'd2; en2 = 1;
    for (int e = 0; e < 4; e++) begin
      iv2 = vin[e]; id2 = din[e];
      tick();
      checks++;
      if (ov2 !== wv[e] || od2 !== wd[e]) begin
        errors++;
        $display("FAIL gap_edge%0d got v=%b d=%h want v=%b d=%h", e + 1, ov2, od2, wv[e], wd[e]);
      end
    end
    rst = 1; iv2 = 1; id2 = 4'hE; fl2 = 1;
    tick();
    rst = 0; en2 = 0; fl2 = 0;
    for (int s = 1; s <= 2; s++) begin
      sel2 = 2'(s);
      #1;
      checks++;
      if ({ov2, od2, occ2} !== 7'd0) begin
        errors++;
        $display("FAIL midreset_sel%0d got v=%b d=%h occ=%0d want v=0 d=0 occ=0", s, ov2, od2, occ2);
      end
    end
  endtask

  task automatic test_random();
    word_t e2, e4;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en2  = 1'($urandom_range(0, 3) != 0);
      iv2  = 1'($urandom);
      id2  = 4'($urandom);
      fl2  = ($urandom_range(0, 19) == 0);
      sel2 = 2'($urandom_range(0, 3));
      en4  = 1'($urandom_range(0, 3) != 0);
      iv4  = 1'($urandom);
      id4  = 4'($urandom);
      fl4  = ($urandom_range(0, 19) == 0);
      sel4 = 3'($urandom_range(0, 7));
      tick();
      e2 = exp2();
      e4 = exp4();
      checks++;
      if (ov2 !== e2.v || od2 !== e2.d || occ2 !== 2'(count_valid2())) begin
        errors++;
        $display("FAIL rand_d2 cyc%0d sel=%0d got v=%b d=%h occ=%0d want v=%b d=%h occ=%0d",
                 n, sel2, ov2, od2, occ2, e2.v, e2.d, count_valid2());
      end
      checks++;
      if (ov4 !== e4.v || od4 !== e4.d || occ4 !== 3'(count_valid4())) begin
        errors++;
        $display("FAIL rand_d4 cyc%0d sel=%0d got v=%b d=%h occ=%0d want v=%b d=%h occ=%0d",
                 n, sel4, ov4, od4, occ4, e4.v, e4.d, count_valid4());
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) m2.push_back('0);
    for (int i = 0; i < 4; i++) m4.push_back('0);
    rst = 1;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_hold();
    test_tap_sweep();
    test_flush();
    test_gap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
